// File: rtl/lx32_reg_generic.sv
// lx32_reg_generic: enable-gated storage register with asynchronous reset.
// Holds the current value and the value before the most recent accepted write.
// Also gives a one-cycle "changed" pulse.
// Optional feature macro: REG_GENERIC_PARITY_EN adds a stored even-parity flop
// and a registered parity_err output.
module lx32_reg_generic #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] WRITE_MASK  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_prev,
`ifdef REG_GENERIC_PARITY_EN
    output logic             changed,
    output logic             parity_err
`else
    output logic             changed
`endif
);

    // Masked bits always read back their reset value, whatever is written.
    logic [WIDTH-1:0] next_val;
    assign next_val = (data_in & WRITE_MASK) | (RESET_VALUE & ~WRITE_MASK);

    // Main storage: on an accepted write, capture the new value and shift the old one into data_prev.
    // An X on en fails the if-test and falls into the hold branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= RESET_VALUE;
            data_prev <= RESET_VALUE;
        end else if (en) begin
            data_prev <= data_out;
            data_out  <= next_val;
        end
    end

    // The change pulse lasts one cycle and only follows an accepted write that altered the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed <= 1'b0;
        end else if (en) begin
            changed <= (next_val != data_out);
        end else begin
            changed <= 1'b0;
        end
    end

`ifdef REG_GENERIC_PARITY_EN
    // Even parity of the stored word, kept in a separate flop so that corruption of either side can be seen.
    logic parity_q;

    // The parity flop tracks every accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= ^RESET_VALUE;
        end else if (en) begin
            parity_q <= ^next_val;
        end
    end

    // The mismatch flag is registered so that no combinational path reaches the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (^data_out) ^ parity_q;
        end
    end
`endif

`ifndef SYNTHESIS
    // Unknown control or write data at a sampling edge points to an upstream bug.
    a_en_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(en));
    a_data_known: assert property (@(posedge clk) disable iff (rst) en |-> !$isunknown(data_in));
`endif

endmodule

// File: tb/tb_lx32_reg_generic.sv
// Directed testbench for lx32_reg_generic with a 16-bit plain instance and a 16-bit masked instance.
module tb_lx32_reg_generic;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out, data_prev;
    logic        changed;
    logic        en_m = 1'b0;
    logic [15:0] data_in_m = '0;
    logic [15:0] m_out, m_prev;
    logic        m_changed;
`ifdef REG_GENERIC_PARITY_EN
    logic        parity_err, m_parity_err;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lx32_reg_generic #(.WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in),
        .data_out(data_out), .data_prev(data_prev),
`ifdef REG_GENERIC_PARITY_EN
        .changed(changed), .parity_err(parity_err)
`else
        .changed(changed)
`endif
    );

    lx32_reg_generic #(.WIDTH(16), .RESET_VALUE(16'h1200), .WRITE_MASK(16'h00FF)) u_mask (
        .clk(clk), .rst(rst), .en(en_m), .data_in(data_in_m),
        .data_out(m_out), .data_prev(m_prev),
`ifdef REG_GENERIC_PARITY_EN
        .changed(m_changed), .parity_err(m_parity_err)
`else
        .changed(m_changed)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; data_in = '0;
        tick(); tick();
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h exp=0000", data_out); end
        total++; if (data_prev !== 16'h0000) begin bad++; $display("FAIL reset_prev got=%h exp=0000", data_prev); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", changed); end
        total++; if (m_out !== 16'h1200) begin bad++; $display("FAIL reset_mask_out got=%h exp=1200", m_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        data_in = 16'hA5A5; en = 1'b0;
        tick();
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL write_disabled got=%h exp=0000", data_out); end
        en = 1'b1;
        tick();
        en = 1'b0;
        total++; if (data_out !== 16'hA5A5) begin bad++; $display("FAIL write_out got=%h exp=a5a5", data_out); end
        total++; if (data_prev !== 16'h0000) begin bad++; $display("FAIL write_prev got=%h exp=0000", data_prev); end
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL write_changed got=%b exp=1", changed); end
        tick();
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL write_pulse_end got=%b exp=0", changed); end
    endtask

    task automatic test_hold();
        en = 1'b0; data_in = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (data_out !== 16'hA5A5 || changed !== 1'b0) begin
                bad++; $display("FAIL hold_%0d got=%h/%b exp=a5a5/0", i, data_out, changed);
            end
        end
    endtask

    task automatic test_same_value();
        en = 1'b1; data_in = 16'hA5A5;
        tick();
        en = 1'b0;
        total++; if (data_out !== 16'hA5A5) begin bad++; $display("FAIL same_out got=%h exp=a5a5", data_out); end
        total++; if (data_prev !== 16'hA5A5) begin bad++; $display("FAIL same_prev got=%h exp=a5a5", data_prev); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL same_changed got=%b exp=0", changed); end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; data_in = 16'h1111;
        tick();
        total++; if (data_out !== 16'h1111 || data_prev !== 16'hA5A5 || changed !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=%h/%h/%b exp=1111/a5a5/1", data_out, data_prev, changed);
        end
        data_in = 16'h2222;
        tick();
        total++; if (data_out !== 16'h2222 || data_prev !== 16'h1111 || changed !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%h/%h/%b exp=2222/1111/1", data_out, data_prev, changed);
        end
        en = 1'b0;
        tick();
        total++; if (data_out !== 16'h2222 || changed !== 1'b0) begin
            bad++; $display("FAIL b2b_hold got=%h/%b exp=2222/0", data_out, changed);
        end
    endtask

    task automatic test_mask();
        en_m = 1'b1; data_in_m = 16'hFFFF;
        tick();
        total++; if (m_out !== 16'h12FF || m_prev !== 16'h1200 || m_changed !== 1'b1) begin
            bad++; $display("FAIL mask_ones got=%h/%h/%b exp=12ff/1200/1", m_out, m_prev, m_changed);
        end
        data_in_m = 16'h0000;
        tick();
        total++; if (m_out !== 16'h1200 || m_prev !== 16'h12FF) begin
            bad++; $display("FAIL mask_zeros got=%h/%h exp=1200/12ff", m_out, m_prev);
        end
        data_in_m = 16'hAB00;
        tick();
        en_m = 1'b0;
        total++; if (m_out !== 16'h1200 || m_changed !== 1'b0) begin
            bad++; $display("FAIL mask_highonly got=%h/%b exp=1200/0", m_out, m_changed);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; data_in = 16'h5A5A;
        tick();
        en = 1'b0;
        total++; if (data_out !== 16'h5A5A) begin bad++; $display("FAIL async_pre got=%h exp=5a5a", data_out); end
        #2 rst = 1'b1;
        #1;
        total++; if (data_out !== 16'h0000 || data_prev !== 16'h0000 || changed !== 1'b0) begin
            bad++; $display("FAIL async_clear got=%h/%h/%b exp=0000/0000/0", data_out, data_prev, changed);
        end
        en = 1'b1; data_in = 16'hFFFF;
        tick();
        total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL async_held got=%h exp=0000", data_out); end
        rst = 1'b0; data_in = 16'hBEEF;
        tick();
        en = 1'b0;
        total++; if (data_out !== 16'hBEEF || data_prev !== 16'h0000 || changed !== 1'b1) begin
            bad++; $display("FAIL async_first_write got=%h/%h/%b exp=beef/0000/1", data_out, data_prev, changed);
        end
    endtask

`ifdef REG_GENERIC_PARITY_EN
    task automatic test_parity();
        en = 1'b1; data_in = 16'h0001;
        tick();
        en = 1'b0;
        tick();
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_clean got=%b exp=0", parity_err); end
        force u_dut.parity_q = 1'b0;
        tick();
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL parity_fault got=%b exp=1", parity_err); end
        release u_dut.parity_q;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_after_reset got=%b exp=0", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_hold();
        test_same_value();
        test_back_to_back();
        test_mask();
        test_async_reset();
`ifdef REG_GENERIC_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
